// File: rtl/verdict_stream_collector.sv
// Timestamps every cycle carrying an active monitor output, buffers the records in a FIFO and
// serializes each as a header word followed by one 64-bit word per active stream.
module verdict_stream_collector #(
    parameter int N_OUT = 12,
    parameter int DEPTH = 8,
    parameter int TS_W  = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_OUT*64-1:0]       out_vals,
    input  logic [N_OUT-1:0]          out_aktv,
    output logic [63:0]               m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [15:0]               drop_count,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [TS_W-1:0]      ts_q;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q, level_d;
    logic [15:0]          drop_q;
    logic                 ovf_q;

    logic [TS_W-1:0]      ts_mem   [DEPTH];
    logic [N_OUT-1:0]     aktv_mem [DEPTH];
    logic [N_OUT*64-1:0]  val_mem  [DEPTH];

    logic                 capture_s, push_s, drop_s, pop_s, last_s;
    logic [N_OUT-1:0]     head_aktv_s;
    logic [N_OUT*64-1:0]  head_vals_s;
    logic [63:0]          hdr_s;

    // Lowest set bit of a at or above position from.
    function automatic logic [IW-1:0] first_set(input logic [N_OUT-1:0] a, input logic [IW:0] from);
        logic [IW-1:0] r;
        r = '0;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            if ((i >= int'(from)) && a[i]) r = IW'(i);
        end
        return r;
    endfunction

    function automatic logic is_last(input logic [N_OUT-1:0] a, input logic [IW-1:0] idx);
        logic r;
        r = 1'b1;
        for (int i = 0; i < N_OUT; i++) begin
            if ((i > int'(idx)) && a[i]) r = 1'b0;
        end
        return r;
    endfunction

    assign capture_s   = en && (|out_aktv);
    assign push_s      = capture_s && (level_q < LW'(DEPTH));
    assign drop_s      = capture_s && !(level_q < LW'(DEPTH));
    assign head_aktv_s = aktv_mem[rd_ptr_q];
    assign head_vals_s = val_mem[rd_ptr_q];
    assign last_s      = is_last(head_aktv_s, idx_q);

    // Header packing: timestamp in [47:0], active mask directly above it.
    always_comb begin
        hdr_s = 64'd0;
        hdr_s[TS_W-1:0] = ts_mem[rd_ptr_q];
        hdr_s[48 +: N_OUT] = head_aktv_s;
    end

    // Serializer next-state and stream outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pop_s   = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) state_d = S_HDR;
                else               state_d = S_IDLE;
            end
            S_HDR: begin
                m_valid = 1'b1;
                m_data  = hdr_s;
                if (m_ready) begin
                    state_d = S_DATA;
                    idx_d   = first_set(head_aktv_s, '0);
                end else begin
                    state_d = S_HDR;
                end
            end
            S_DATA: begin
                m_valid = 1'b1;
                m_data  = head_vals_s[{idx_q, 6'd0} +: 64];
                m_last  = last_s;
                if (m_ready && last_s) begin
                    pop_s   = 1'b1;
                    state_d = S_IDLE;
                end else if (m_ready) begin
                    idx_d = first_set(head_aktv_s, {1'b0, idx_q} + {{IW{1'b0}}, 1'b1});
                end else begin
                    idx_d = idx_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Occupancy: a push and a pop in the same cycle cancel out.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state, pointers, timestamp and drop statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= 16'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            if (en) ts_q <= ts_q + TS_W'(1);
            if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (drop_s) begin
                ovf_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Record storage needs no reset: only slots behind a valid level are ever read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            ts_mem[wr_ptr_q]   <= ts_q;
            aktv_mem[wr_ptr_q] <= out_aktv;
            val_mem[wr_ptr_q]  <= out_vals;
        end
    end

    assign fifo_level = level_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_verdict_stream_collector.sv
// Directed bench for verdict_stream_collector: reset, single record, backpressure, overflow,
// full-FIFO push/pop collision and reset in the middle of a record.
module tb_verdict_stream_collector;

    localparam int N_OUT = 12;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic [N_OUT*64-1:0]  out_vals;
    logic [N_OUT-1:0]     out_aktv;
    logic [63:0]          m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;
    logic [3:0]           fifo_level;
    logic [15:0]          drop_count;
    logic                 overflow;

    int                   n_checks;
    int                   n_errors;
    logic [47:0]          ts_exp;
    logic [47:0]          cap_ts;
    logic [47:0]          base_ts;

    verdict_stream_collector #(.N_OUT(N_OUT), .DEPTH(8), .TS_W(48)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .out_vals   (out_vals),
        .out_aktv   (out_aktv),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .fifo_level (fifo_level),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the expected timestamp follows the same rules as the counter.
    task automatic tick();
        @(posedge clk);
        if (rst) ts_exp = 48'd0;
        else if (en) ts_exp = ts_exp + 48'd1;
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid"}, 64'(m_valid), 64'd1);
    endtask

    task automatic get_word(input string tag, input logic [63:0] d, input logic l);
        wait_valid(tag);
        check_eq({tag, "_data"}, m_data, d);
        check_eq({tag, "_last"}, 64'(m_last), 64'(l));
        tick();
    endtask

    function automatic logic [63:0] hdr(input logic [11:0] a, input logic [47:0] ts);
        return {4'h0, a, ts};
    endfunction

    task automatic set_bulk_vals(input int j);
        for (int i = 0; i < N_OUT; i++) out_vals[i*64 +: 64] = 64'(j * 16 + i);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ts_exp   = 48'd0;
        rst      = 1'b1;
        en       = 1'b0;
        m_ready  = 1'b0;
        out_aktv = 12'd0;
        out_vals = '0;

        // Reset
        tick();
        tick();
        check_eq("rst_valid", 64'(m_valid), 64'd0);
        check_eq("rst_last", 64'(m_last), 64'd0);
        check_eq("rst_data", m_data, 64'd0);
        check_eq("rst_level", 64'(fifo_level), 64'd0);
        check_eq("rst_drop", 64'(drop_count), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle_valid", 64'(m_valid), 64'd0);
        end
        while (ts_exp != 48'd500) tick();

        // Single record at ts=500
        m_ready  = 1'b1;
        out_aktv = 12'b0000_0000_0101;
        out_vals[0*64 +: 64] = 64'd1;
        out_vals[2*64 +: 64] = -64'sd3;
        tick();
        out_aktv = 12'd0;
        check_eq("s_level1", 64'(fifo_level), 64'd1);
        check_eq("s_valid0", 64'(m_valid), 64'd0);
        tick();
        check_eq("s_hdr_valid", 64'(m_valid), 64'd1);
        check_eq("s_hdr", m_data, 64'h0005_0000_0000_01F4);
        check_eq("s_hdr_last", 64'(m_last), 64'd0);
        tick();
        check_eq("s_w0", m_data, 64'd1);
        check_eq("s_w0_last", 64'(m_last), 64'd0);
        tick();
        check_eq("s_w1", m_data, 64'hFFFF_FFFF_FFFF_FFFD);
        check_eq("s_w1_last", 64'(m_last), 64'd1);
        tick();
        check_eq("s_end_valid", 64'(m_valid), 64'd0);
        check_eq("s_level0", 64'(fifo_level), 64'd0);

        // Backpressure during DATA
        out_vals = '0;
        out_aktv = 12'h802;
        out_vals[1*64 +: 64]  = 64'h1234;
        out_vals[11*64 +: 64] = 64'h8000_0000_0000_0000;
        cap_ts = ts_exp;
        tick();
        out_aktv = 12'd0;
        get_word("bp_hdr", hdr(12'h802, cap_ts), 1'b0);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold_valid", 64'(m_valid), 64'd1);
            check_eq("bp_hold_data", m_data, 64'h1234);
            check_eq("bp_hold_last", 64'(m_last), 64'd0);
        end
        m_ready = 1'b1;
        get_word("bp_w0", 64'h1234, 1'b0);
        get_word("bp_w1", 64'h8000_0000_0000_0000, 1'b1);
        check_eq("bp_end_valid", 64'(m_valid), 64'd0);
        check_eq("bp_level0", 64'(fifo_level), 64'd0);

        // Overflow: 10 captures into an 8-deep FIFO with the sink stalled
        m_ready  = 1'b0;
        base_ts  = ts_exp;
        out_aktv = 12'hFFF;
        for (int j = 0; j < 10; j++) begin
            set_bulk_vals(j);
            tick();
        end
        out_aktv = 12'd0;
        check_eq("ov_level", 64'(fifo_level), 64'd8);
        check_eq("ov_drop", 64'(drop_count), 64'd2);
        check_eq("ov_flag", 64'(overflow), 64'd1);
        check_eq("ov_hdr_held", m_data, hdr(12'hFFF, base_ts));

        // Drain record 0, colliding a capture with its final handshake
        m_ready = 1'b1;
        get_word("ov_r0_hdr", hdr(12'hFFF, base_ts), 1'b0);
        for (int i = 0; i < N_OUT - 1; i++) get_word("ov_r0_w", 64'(i), 1'b0);
        wait_valid("pp_last");
        check_eq("pp_last_data", m_data, 64'(N_OUT - 1));
        check_eq("pp_last_flag", 64'(m_last), 64'd1);
        check_eq("pp_level_pre", 64'(fifo_level), 64'd8);
        out_aktv = 12'hFFF;
        set_bulk_vals(99);
        tick();
        out_aktv = 12'd0;
        check_eq("pp_drop", 64'(drop_count), 64'd3);
        check_eq("pp_level", 64'(fifo_level), 64'd7);

        for (int j = 1; j < 8; j++) begin
            get_word("ov_hdr", hdr(12'hFFF, base_ts + 48'(j)), 1'b0);
            for (int i = 0; i < N_OUT; i++) get_word("ov_w", 64'(j * 16 + i), i == N_OUT - 1);
        end
        tick();
        tick();
        check_eq("ov_end_valid", 64'(m_valid), 64'd0);
        check_eq("ov_end_level", 64'(fifo_level), 64'd0);

        // Reset after header accepted
        out_vals = '0;
        out_aktv = 12'h003;
        out_vals[0*64 +: 64] = 64'hA;
        out_vals[1*64 +: 64] = 64'hB;
        cap_ts = ts_exp;
        tick();
        out_aktv = 12'd0;
        get_word("mr_hdr", hdr(12'h003, cap_ts), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mr_valid", 64'(m_valid), 64'd0);
        check_eq("mr_last", 64'(m_last), 64'd0);
        check_eq("mr_level", 64'(fifo_level), 64'd0);
        check_eq("mr_drop", 64'(drop_count), 64'd0);
        check_eq("mr_ovf", 64'(overflow), 64'd0);
        tick();
        tick();
        out_aktv = 12'h004;
        out_vals[2*64 +: 64] = 64'h77;
        cap_ts = ts_exp;
        tick();
        out_aktv = 12'd0;
        get_word("mr_new_hdr", hdr(12'h004, cap_ts), 1'b0);
        get_word("mr_new_w", 64'h77, 1'b1);
        check_eq("mr_new_level", 64'(fifo_level), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
